// File: rtl/sram_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_controller                                                 |
// | Brief    : MEM-stage controller for a 16-bit external SRAM. Each 32-bit    |
// |            load/store is split into a low and a high half-word access,     |
// |            followed by WAIT_CYCLES wait states and a one-cycle ready.      |
// |            Optional single-entry read buffer enabled by the macro          |
// |            SRAM_RDBUF_EN (default build: buffer absent).                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sram_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          SRAM_AW     = 18,
  parameter int          WAIT_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic               pause,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in
);

  // Last wait-state count value; irrelevant when there are no wait states.
  localparam logic [3:0] c_wait_last = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             r_state;
  logic               r_is_wr;
  logic [15:0]        r_wdata_hi;
  logic [SRAM_AW-2:0] r_word_idx;
  logic [3:0]         r_wait_cnt;
  logic [31:0]        r_read_data;
  logic               r_ready;

  logic [31:0]        w_off;
  logic [SRAM_AW-2:0] w_word_idx;
  logic               w_req;
  logic               w_hit;
  logic               w_start;
  logic               w_unused_off_bits;

  // Byte offset into the SRAM window; bits above the SRAM range simply alias.
  assign w_off             = address - BASE_ADDR;
  assign w_word_idx        = w_off[SRAM_AW:2];
  assign w_unused_off_bits = ^{w_off[31:SRAM_AW+1], w_off[1:0]};
  assign w_req             = wr_en | rd_en;
  // A buffer hit is answered in IDLE without touching the SRAM.
  assign w_start           = (r_state == S_IDLE) & w_req & ~w_hit;

`ifdef SRAM_RDBUF_EN
  logic        r_buf_valid;
  logic [31:0] r_buf_tag;
  logic [31:0] r_buf_data;
  logic [31:0] r_req_addr;

  assign w_hit = (r_state == S_IDLE) & rd_en & ~wr_en & r_buf_valid & (r_buf_tag == address);

  // Read buffer: refilled by every completed read, invalidated by a store to the tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf_valid <= 1'b0;
      r_buf_tag   <= 32'd0;
      r_buf_data  <= 32'd0;
      r_req_addr  <= 32'd0;
    end else begin
      if (w_start) begin
        r_req_addr <= address;
        if (wr_en && (address == r_buf_tag)) begin
          r_buf_valid <= 1'b0;
        end
      end
      if ((r_state == S_DONE) && !r_is_wr) begin
        r_buf_valid <= 1'b1;
        r_buf_tag   <= r_req_addr;
        r_buf_data  <= r_read_data;
      end
    end
  end

  assign read_data = w_hit ? r_buf_data : r_read_data;
`else
  assign w_hit     = 1'b0;
  assign read_data = r_read_data;
`endif

  assign ready = r_ready | w_hit;
  assign pause = w_req & ~ready;

  // Transaction sequencer; all SRAM pins are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_is_wr     <= 1'b0;
      r_wdata_hi  <= 16'd0;
      r_word_idx  <= '0;
      r_wait_cnt  <= 4'd0;
      r_read_data <= 32'd0;
      r_ready     <= 1'b0;
      sram_addr   <= '0;
      sram_we_n   <= 1'b1;
      sram_dq_out <= 16'd0;
      sram_dq_oe  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            // Store wins when both requests are raised together.
            r_state     <= S_LO;
            r_is_wr     <= wr_en;
            r_wdata_hi  <= write_data[31:16];
            r_word_idx  <= w_word_idx;
            sram_addr   <= {w_word_idx, 1'b0};
            sram_we_n   <= ~wr_en;
            sram_dq_oe  <= wr_en;
            sram_dq_out <= write_data[15:0];
          end
        end
        S_LO: begin
          if (!r_is_wr) begin
            r_read_data[15:0] <= sram_dq_in;
          end
          sram_addr   <= {r_word_idx, 1'b1};
          sram_dq_out <= r_wdata_hi;
          r_state     <= S_HI;
        end
        S_HI: begin
          if (!r_is_wr) begin
            r_read_data[31:16] <= sram_dq_in;
          end
          sram_we_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
          r_wait_cnt <= 4'd0;
          if (WAIT_CYCLES == 0) begin
            r_state <= S_DONE;
            r_ready <= 1'b1;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_wait_cnt == c_wait_last) begin
            r_wait_cnt <= 4'd0;
            r_state    <= S_DONE;
            r_ready    <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end
        S_DONE: begin
          r_ready <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_ready    <= 1'b0;
          sram_we_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sram_controller                                              |
// | Brief    : Self-checking bench for sram_controller: directed table,        |
// |            hand-written corner sequences and a randomized run against a    |
// |            word-level memory model. Honours SRAM_RDBUF_EN.                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_sram_controller;

  localparam int          AW    = 18;
  localparam logic [31:0] BASE  = 32'd1024;
  localparam int          WAITC = 3;
  localparam int          LAT   = 3 + WAITC;
`ifdef SRAM_RDBUF_EN
  localparam int          LAT_HIT = 0;
`else
  localparam int          LAT_HIT = LAT;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0]   address = 32'd0, write_data = 32'd0, read_data;
  logic          ready, pause;
  logic [AW-1:0] sram_addr;
  logic          sram_we_n, sram_dq_oe;
  logic [15:0]   sram_dq_out, sram_dq_in;

  logic          z_wr = 1'b0, z_rd = 1'b0;
  logic [31:0]   z_addr = 32'd0, z_wd = 32'd0, z_read_data;
  logic          z_ready, z_pause, z_we_n, z_oe;
  logic [AW-1:0] z_sram_addr;
  logic [15:0]   z_dq_out, z_dq_in;

  bit [15:0]     mem   [0:(1<<AW)-1];
  bit            wmask [0:(1<<AW)-1];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sram_controller #(.BASE_ADDR(BASE), .SRAM_AW(AW), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready), .pause(pause),
    .sram_addr(sram_addr), .sram_we_n(sram_we_n), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in)
  );

  sram_controller #(.BASE_ADDR(BASE), .SRAM_AW(AW), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst), .wr_en(z_wr), .rd_en(z_rd), .address(z_addr),
    .write_data(z_wd), .read_data(z_read_data), .ready(z_ready), .pause(z_pause),
    .sram_addr(z_sram_addr), .sram_we_n(z_we_n), .sram_dq_out(z_dq_out),
    .sram_dq_oe(z_dq_oe_unused_sink), .sram_dq_in(z_dq_in)
  );
  logic z_dq_oe_unused_sink;
  assign z_oe = z_dq_oe_unused_sink;

  // Power-up SRAM contents: fixed pattern, with 0xBEEF/0xCAFE at half-words 2/3.
  function automatic logic [15:0] init_half(input int a);
    if (a == 2) return 16'hBEEF;
    if (a == 3) return 16'hCAFE;
    return 16'(a) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] peek(input int a);
    return wmask[a] ? mem[a] : init_half(a);
  endfunction

  // Word index of a byte address inside the SRAM window (wrapping, truncating).
  function automatic int word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off >> 2) & ((32'd1 << (AW - 1)) - 32'd1));
  endfunction

  assign sram_dq_in = peek(int'(sram_addr));
  assign z_dq_in    = ~z_sram_addr[15:0];

  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) begin
      mem[sram_addr]   <= sram_dq_out;
      wmask[sram_addr] <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Runs one request from an IDLE-cycle start; returns at posedge+1 after ready.
  task automatic run_txn(input logic wr, input logic rd, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output int we_cnt,
                         output int pause_bad, output logic [31:0] rdata);
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    lat = -1; we_cnt = 0; pause_bad = 0; rdata = 32'hx;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!sram_we_n) we_cnt++;
      if (ready) begin
        if (pause !== 1'b0) pause_bad++;
        lat   = c;
        rdata = read_data;
      end else if (pause !== 1'b1) begin
        pause_bad++;
      end
      @(posedge clk); #1;
      if (lat >= 0) break;
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t        tbl [9];
  int          lat, we_cnt, pbad, k, r1, r2, idle_n;
  logic [31:0] rdv, exp_rd, last_rd, a, d, buf_addr;
  logic        wr, rd, buf_valid, hit;
  logic [31:0] ref_mem [int];

  initial begin
    tbl[0] = '{1'b0, 1'b1, 32'd1028, 32'd0,         32'hCAFEBEEF, LAT};
    tbl[1] = '{1'b1, 1'b1, 32'd1032, 32'hA1B2C3D4, 32'hCAFEBEEF, LAT};
    tbl[2] = '{1'b0, 1'b1, 32'd1028, 32'd0,         32'hCAFEBEEF, LAT_HIT};
    tbl[3] = '{1'b1, 1'b0, 32'd1028, 32'h0BADF00D, 32'hCAFEBEEF, LAT};
    tbl[4] = '{1'b0, 1'b1, 32'd1028, 32'd0,         32'h0BADF00D, LAT};
    tbl[5] = '{1'b0, 1'b1, 32'd1032, 32'd0,         32'hA1B2C3D4, LAT};
    tbl[6] = '{1'b1, 1'b0, 32'd1020, 32'h55AA33CC, 32'hA1B2C3D4, LAT};
    tbl[7] = '{1'b0, 1'b1, 32'd1020, 32'd0,         32'h55AA33CC, LAT};
    tbl[8] = '{1'b0, 1'b1, BASE + (32'd1 << (AW + 1)), 32'd0, 32'h12345678, LAT};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_read_data", read_data, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_pause", {31'd0, pause}, 32'd0);
    check("rst_sram_addr", 32'(sram_addr), 32'd0);
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("rst_dq_out", 32'(sram_dq_out), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Store 0x12345678 at 1024, cycle by cycle
    wr_en = 1'b1; address = 32'd1024; write_data = 32'h12345678;
    @(negedge clk);
    check("wr_c0_pause", {31'd0, pause}, 32'd1);
    check("wr_c0_we_n", {31'd0, sram_we_n}, 32'd1);
    @(negedge clk);
    check("wr_c1_addr", 32'(sram_addr), 32'd0);
    check("wr_c1_dq", 32'(sram_dq_out), 32'h5678);
    check("wr_c1_we_oe", {30'd0, sram_we_n, sram_dq_oe}, 32'd1);
    @(negedge clk);
    check("wr_c2_addr", 32'(sram_addr), 32'd1);
    check("wr_c2_dq", 32'(sram_dq_out), 32'h1234);
    check("wr_c2_we_oe", {30'd0, sram_we_n, sram_dq_oe}, 32'd1);
    @(negedge clk);
    check("wr_c3_we_oe", {30'd0, sram_we_n, sram_dq_oe}, 32'd2);
    @(negedge clk);
    check("wr_c4_rdy_pause", {30'd0, ready, pause}, 32'd1);
    @(negedge clk);
    check("wr_c5_rdy_pause", {30'd0, ready, pause}, 32'd1);
    @(negedge clk);
    check("wr_c6_rdy_pause", {30'd0, ready, pause}, 32'd2);
    @(posedge clk); #1;
    wr_en = 1'b0;
    check("wr_mem", {16'(peek(1)), 16'(peek(0))}, 32'h12345678);

    // Directed table
    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].d, lat, we_cnt, pbad, rdv);
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      check($sformatf("tbl%0d_read_data", i), rdv, tbl[i].exp_rd);
      check($sformatf("tbl%0d_we_pulses", i), 32'(we_cnt), tbl[i].wr ? 32'd2 : 32'd0);
      check($sformatf("tbl%0d_pause", i), 32'(pbad), 32'd0);
      if (tbl[i].wr) begin
        k = word_idx(tbl[i].a);
        check($sformatf("tbl%0d_mem", i), {peek(2*k+1), peek(2*k)}, tbl[i].d);
      end
    end
    check("alias_low_addr", 32'(word_idx(32'd1020)), 32'h1FFFF);

    // Reset during cycle 2 of a store
    wr_en = 1'b1; address = BASE + 32'd800; write_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid_rst_outs", {28'd0, sram_we_n, sram_dq_oe, ready, 1'b0}, 32'h8);
    check("mid_rst_addr_dq", {14'(sram_addr), 16'(sram_dq_out)}, 32'd0);
    check("mid_rst_read_data", read_data, 32'd0);
    wr_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    we_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!sram_we_n || ready) we_cnt++;
    end
    @(posedge clk); #1;
    check("post_rst_quiet", 32'(we_cnt), 32'd0);
    check("post_rst_hi_unwritten", {31'd0, wmask[401]}, 32'd0);
    // Buffer (if present) must have been cleared by reset
    run_txn(1'b0, 1'b1, tbl[8].a, 32'd0, lat, we_cnt, pbad, rdv);
    check("post_rst_read_lat", 32'(lat), 32'(LAT));
    check("post_rst_read_data", rdv, 32'h12345678);

    // Randomized traffic against a word-level model
    last_rd = 32'h12345678;
    buf_valid = 1'b0; buf_addr = 32'd0;
    for (int i = 0; i < 60; i++) begin
      a  = BASE + 32'd4096 + 32'(4 * $urandom_range(0, 7));
      d  = $urandom;
      wr = ($urandom_range(0, 2) == 0);
      rd = !wr || ($urandom_range(0, 3) == 0);
      k  = word_idx(a);
      hit = 1'b0;
`ifdef SRAM_RDBUF_EN
      hit = rd && !wr && buf_valid && (buf_addr == a);
`endif
      if (wr) begin
        ref_mem[k] = d;
        if (a == buf_addr) buf_valid = 1'b0;
      end else begin
        last_rd = ref_mem.exists(k) ? ref_mem[k] : {init_half(2*k+1), init_half(2*k)};
        buf_valid = 1'b1;
        buf_addr  = a;
      end
      exp_rd = last_rd;
      run_txn(wr, rd, a, d, lat, we_cnt, pbad, rdv);
      check($sformatf("rnd%0d_latency", i), 32'(lat), hit ? 32'd0 : 32'(LAT));
      check($sformatf("rnd%0d_read_data", i), rdv, exp_rd);
      check($sformatf("rnd%0d_we_pulses", i), 32'(we_cnt), wr ? 32'd2 : 32'd0);
      check($sformatf("rnd%0d_pause", i), 32'(pbad), 32'd0);
      idle_n = $urandom_range(0, 2);
      repeat (idle_n) @(posedge clk);
      #0;
    end

    // Zero wait states: back-to-back load then store
    r1 = -1; r2 = -1;
    z_rd = 1'b1; z_addr = 32'd1028; z_wd = 32'h600DF00D;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (z_ready) begin
        if (r1 < 0) begin
          r1  = c;
          rdv = z_read_data;
        end else if (r2 < 0) begin
          r2 = c;
        end
      end
      @(posedge clk); #1;
      if (r1 == c) begin z_rd = 1'b0; z_wr = 1'b1; end
      if (r2 == c) begin z_wr = 1'b0; break; end
    end
    z_rd = 1'b0; z_wr = 1'b0;
    check("zw_first_ready", 32'(r1), 32'd3);
    check("zw_second_ready", 32'(r2), 32'd7);
    check("zw_read_data", rdv, 32'hFFFCFFFD);
    check("zw_read_data_after_wr", z_read_data, 32'hFFFCFFFD);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  logic z_unused_sink;
  assign z_unused_sink = ^{z_pause, z_we_n, z_oe, z_dq_out};

endmodule
`default_nettype wire
